lot_occupancy: RTL and testbench
================================

# lot_occupancy

Downstream consumer of the parking-lot entry/exit sensor FSM. Turns its one-cycle `enter`/`exit` pulses into a saturating occupancy count with full/empty flags. Tracks a day of `NUM_HOURS` hours, logging entries per hour, and detects rush hour: the first time the lot fills, and the subsequent time it empties. Outputs drive the lab's HEX/LED display logic and the per-hour readout.

## Interface
- `CAPACITY`, 3 — lot spaces; occupancy ranges 0..CAPACITY.
- `NUM_HOURS`, 8 — hours in the tracked day.
- `CNT_W`, 4 — width of each per-hour entry counter; saturates at 2^CNT_W-1.
- `clk`  in  1  — single system clock.
- `reset`  in  1  — asynchronous, active-low reset.
- `enter`  in  1  — one-cycle pulse: a car entered.
- `exit`  in  1  — one-cycle pulse: a car left.
- `next_hour`  in  1  — one-cycle pulse: advance the hour.
- `rd_hour`  in  $clog2(NUM_HOURS)  — hour index for the log readout.
- `occupancy`  out  $clog2(CAPACITY+1)  — cars currently in the lot.
- `full`  out  1  — occupancy == CAPACITY.
- `empty`  out  1  — occupancy == 0.
- `blocked`  out  1  — one-cycle pulse: `enter` arrived while full.
- `hour`  out  $clog2(NUM_HOURS)  — current hour.
- `day_done`  out  1  — sticky; `next_hour` was seen in the last hour.
- `rd_count`  out  CNT_W  — entry count of `rd_hour`, registered.
- `rush_start`, `rush_end`  out  $clog2(NUM_HOURS) each  — rush hour boundaries.
- `rush_start_vld`, `rush_end_vld`  out  1 each  — boundary recorded.

## Operation
- Occupancy:
  - `enter` only: +1 unless full; when full, the count is held and `blocked` pulses.
  - `exit` only: −1 unless empty; when empty, the count is held (exit is ignored).
  - `enter` and `exit` together: count unchanged, log unchanged, no `blocked`.
- `full` and `empty` are combinational decodes of the registered `occupancy`.
- Hour counter:
  - `next_hour` increments `hour` when `hour < NUM_HOURS-1`.
  - At `NUM_HOURS-1`, `next_hour` sets `day_done` and leaves `hour` unchanged.
  - Once `day_done` is set, `enter`/`exit` still update occupancy, but the log and rush FSM freeze.
- Entry log:
  - Each accepted `enter` (count actually increments) adds 1 to `log[hour]`, saturating at 2^CNT_W-1.
  - A blocked entry is not logged.
- Rush FSM, states RUSH_IDLE → RUSH_ON → RUSH_DONE:
  - RUSH_IDLE: on the cycle `occupancy` becomes CAPACITY, latch `rush_start=hour`, set `rush_start_vld`, go to RUSH_ON.
  - RUSH_ON: on the cycle `occupancy` becomes 0, latch `rush_end=hour`, set `rush_end_vld`, go to RUSH_DONE.
  - RUSH_DONE: terminal until reset. Refilling the lot does not restart rush detection.
- If the day ends while in RUSH_ON, `rush_end_vld` stays 0.

## Timing
- Reset (async assert, sync-safe release) values:
  - `occupancy`=0, `full`=0, `empty`=1, `blocked`=0.
  - `hour`=0, `day_done`=0, all log entries 0, `rd_count`=0.
  - `rush_start`=0, `rush_end`=0, both `_vld`=0, FSM in RUSH_IDLE.
- `occupancy`, `blocked` and the log update on the clock edge that samples the pulse; they are visible the next cycle.
- Rush latches are evaluated on the next-state occupancy. `rush_start_vld` rises in the same cycle `full` rises.
- `next_hour` coincident with `enter`: the entry is logged to the old hour, and `hour` advances on the same edge.
- `rd_count` = `log[rd_hour]` one cycle after `rd_hour` is presented. It reflects writes completed before that edge; there is no write-through bypass.
- Reset mid-day clears everything immediately, independent of `clk`.

## Configuration
- `LOT_HISTORY_EN` defined: entry log, `rd_count` and the rush FSM are built as above.
- Undefined: no log storage and no rush FSM.
  - `rd_count`, `rush_start`, `rush_end` and both `_vld` outputs are tied to 0.
  - Occupancy, `blocked` and hour/`day_done` behave identically.

## Structure
- Shared package `lot_pkg`:
  - `rush_state_t` enum {RUSH_IDLE, RUSH_ON, RUSH_DONE}.
  - Default constants `LOT_CAPACITY`=3 and `LOT_NUM_HOURS`=8, reused by the sensor top level and the display.
- One sub-module, `hour_log`:
  - NUM_HOURS×CNT_W register array.
  - Saturating increment port (`inc`, `idx`) and registered read port (`rd_idx`, `rd_data`).
  - Instantiated only under `LOT_HISTORY_EN`.

## Test plan
- Reset low mid-count (occupancy=2) → all outputs return to reset values within the same cycle, without a clock edge.
- 4 `enter` pulses with CAPACITY=3 → occupancy 1,2,3,3; `full`=1 after the third; `blocked` pulses once on the fourth; log[0]=3.
- From empty, `exit` pulse → occupancy stays 0, `empty`=1. Simultaneous `enter`+`exit` at occupancy 1 → stays 1, log unchanged.
- Fill in hour 2, `next_hour` ×2, empty in hour 4 → `rush_start`=2, `rush_end`=4, both valid. Refill in hour 5 → values unchanged.
- 8 `next_hour` pulses → `hour` reaches 7 and stays there, `day_done`=1. Further `enter` → occupancy increments, log[7] unchanged.
- Build without `LOT_HISTORY_EN`, same stimulus → identical occupancy/`blocked`/`hour`; `rd_count` and rush outputs stay 0.

Source files
------------

// File: rtl/lot_pkg.sv
// Shared types and default sizing for the parking-lot blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lot_pkg;

  // Default lot geometry shared by the sensor top level and the display.
  localparam int LOT_CAPACITY  = 3;
  localparam int LOT_NUM_HOURS = 8;

  // Rush-hour tracker: wait for first fill, then for the following empty.
  typedef enum logic [1:0] {
    RUSH_IDLE,
    RUSH_ON,
    RUSH_DONE
  } rush_state_t;

endpackage

// File: rtl/hour_log.sv
// Per-hour entry counters with a saturating increment and a registered read.
// Latency: increment lands on the sampling edge; rd_data is log[rd_idx] one cycle later.
// Backpressure: none; an increment at saturation is dropped.
// Ports: clk, reset (async active-low), inc/idx (increment log[idx]),
//        rd_idx/rd_data (registered read, no write-through bypass).
module hour_log
  import lot_pkg::*;
#(
  parameter int NUM_HOURS = LOT_NUM_HOURS,
  parameter int CNT_W     = 4,
  localparam int IDX_W    = $clog2(NUM_HOURS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic [IDX_W-1:0] idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_data
);

  logic [CNT_W-1:0] log_q [NUM_HOURS];
  logic [CNT_W-1:0] log_d [NUM_HOURS];
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    log_d = log_q;
    if (inc && (int'(idx) < NUM_HOURS) && (log_q[idx] != '1)) begin
      log_d[idx] = log_q[idx] + CNT_W'(1);
    end
    // Read the pre-edge contents: a same-cycle increment is not visible here.
    rd_data_d = '0;
    if (int'(rd_idx) < NUM_HOURS) begin
      rd_data_d = log_q[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_HOURS; i++) begin
        log_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      log_q     <= log_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/lot_occupancy.sv
// Saturating lot occupancy with full/empty flags, hour-of-day tracking, and
// (with LOT_HISTORY_EN defined) a per-hour entry log plus rush-hour detection.
// Latency: occupancy/blocked/hour/log update on the edge sampling the pulse; rd_count one cycle after rd_hour.
// Backpressure: none; enter while full is dropped and flagged on blocked, exit while empty is ignored.
// Ports: clk, reset (async active-low); enter/exit/next_hour pulses; rd_hour log index;
//        occupancy/full/empty/blocked; hour/day_done; rd_count; rush_start/_end and their _vld.
// Without LOT_HISTORY_EN, rd_count and all rush outputs are tied to 0.
module lot_occupancy
  import lot_pkg::*;
#(
  parameter int CAPACITY  = LOT_CAPACITY,
  parameter int NUM_HOURS = LOT_NUM_HOURS,
  parameter int CNT_W     = 4,
  localparam int OCC_W    = $clog2(CAPACITY + 1),
  localparam int HR_W     = $clog2(NUM_HOURS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter,
  input  logic             exit,
  input  logic             next_hour,
  input  logic [HR_W-1:0]  rd_hour,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             blocked,
  output logic [HR_W-1:0]  hour,
  output logic             day_done,
  output logic [CNT_W-1:0] rd_count,
  output logic [HR_W-1:0]  rush_start,
  output logic [HR_W-1:0]  rush_end,
  output logic             rush_start_vld,
  output logic             rush_end_vld
);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             blocked_q, blocked_d;
  logic [HR_W-1:0]  hour_q, hour_d;
  logic             day_done_q, day_done_d;
  logic             full_c, empty_c;
  logic             acc_enter;

  assign full_c  = (occ_q == OCC_W'(CAPACITY));
  assign empty_c = (occ_q == '0);

  always_comb begin
    occ_d      = occ_q;
    blocked_d  = 1'b0;
    acc_enter  = 1'b0;
    hour_d     = hour_q;
    day_done_d = day_done_q;

    // Simultaneous enter+exit cancel out entirely.
    if (enter && !exit) begin
      if (full_c) begin
        blocked_d = 1'b1;
      end else begin
        occ_d     = occ_q + OCC_W'(1);
        acc_enter = 1'b1;
      end
    end else if (exit && !enter && !empty_c) begin
      occ_d = occ_q - OCC_W'(1);
    end

    // The last hour never wraps; it just marks the day as finished.
    if (next_hour && !day_done_q) begin
      if (hour_q == HR_W'(NUM_HOURS - 1)) begin
        day_done_d = 1'b1;
      end else begin
        hour_d = hour_q + HR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q      <= '0;
      blocked_q  <= 1'b0;
      hour_q     <= '0;
      day_done_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      blocked_q  <= blocked_d;
      hour_q     <= hour_d;
      day_done_q <= day_done_d;
    end
  end

  assign occupancy = occ_q;
  assign full      = full_c;
  assign empty     = empty_c;
  assign blocked   = blocked_q;
  assign hour      = hour_q;
  assign day_done  = day_done_q;

`ifdef LOT_HISTORY_EN
  rush_state_t     rush_q, rush_d;
  logic [HR_W-1:0] rush_start_q, rush_start_d;
  logic [HR_W-1:0] rush_end_q, rush_end_d;
  logic            rush_start_vld_q, rush_start_vld_d;
  logic            rush_end_vld_q, rush_end_vld_d;

  // Entries are logged against the pre-edge hour, and only while the day runs.
  hour_log #(
    .NUM_HOURS (NUM_HOURS),
    .CNT_W     (CNT_W)
  ) u_hour_log (
    .clk     (clk),
    .reset   (reset),
    .inc     (acc_enter && !day_done_q),
    .idx     (hour_q),
    .rd_idx  (rd_hour),
    .rd_data (rd_count)
  );

  // Transitions look at next-state occupancy so rush_start_vld rises with full.
  always_comb begin
    rush_d           = rush_q;
    rush_start_d     = rush_start_q;
    rush_end_d       = rush_end_q;
    rush_start_vld_d = rush_start_vld_q;
    rush_end_vld_d   = rush_end_vld_q;
    if (!day_done_q) begin
      case (rush_q)
        RUSH_IDLE: begin
          if ((occ_d == OCC_W'(CAPACITY)) && !full_c) begin
            rush_start_d     = hour_q;
            rush_start_vld_d = 1'b1;
            rush_d           = RUSH_ON;
          end
        end
        RUSH_ON: begin
          if ((occ_d == '0) && !empty_c) begin
            rush_end_d     = hour_q;
            rush_end_vld_d = 1'b1;
            rush_d         = RUSH_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rush_q           <= RUSH_IDLE;
      rush_start_q     <= '0;
      rush_end_q       <= '0;
      rush_start_vld_q <= 1'b0;
      rush_end_vld_q   <= 1'b0;
    end else begin
      rush_q           <= rush_d;
      rush_start_q     <= rush_start_d;
      rush_end_q       <= rush_end_d;
      rush_start_vld_q <= rush_start_vld_d;
      rush_end_vld_q   <= rush_end_vld_d;
    end
  end

  assign rush_start     = rush_start_q;
  assign rush_end       = rush_end_q;
  assign rush_start_vld = rush_start_vld_q;
  assign rush_end_vld   = rush_end_vld_q;
`else
  logic unused_history;
  assign unused_history = ^{rd_hour, acc_enter};

  assign rd_count       = '0;
  assign rush_start     = '0;
  assign rush_end       = '0;
  assign rush_start_vld = 1'b0;
  assign rush_end_vld   = 1'b0;
`endif

endmodule

// File: tb/tb_lot_occupancy.sv
// Randomized and directed bench for lot_occupancy against a counting model.
// Latency: model expects outputs one edge after each pulse.
// Backpressure: n/a.
module tb_lot_occupancy;

  localparam int CAP = 3;
  localparam int NH  = 8;
  localparam int CW  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enter, exit, next_hour;
  logic [2:0] rd_hour;
  logic [1:0] occupancy;
  logic       full, empty, blocked;
  logic [2:0] hour;
  logic       day_done;
  logic [3:0] rd_count;
  logic [2:0] rush_start, rush_end;
  logic       rush_start_vld, rush_end_vld;

  always #5 clk = ~clk;

  lot_occupancy #(.CAPACITY(CAP), .NUM_HOURS(NH), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .enter          (enter),
    .exit           (exit),
    .next_hour      (next_hour),
    .rd_hour        (rd_hour),
    .occupancy      (occupancy),
    .full           (full),
    .empty          (empty),
    .blocked        (blocked),
    .hour           (hour),
    .day_done       (day_done),
    .rd_count       (rd_count),
    .rush_start     (rush_start),
    .rush_end       (rush_end),
    .rush_start_vld (rush_start_vld),
    .rush_end_vld   (rush_end_vld)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: plain counters and flags.
  int m_occ, m_hour, m_dd, m_blk, m_rd;
  int m_log [NH];
  int m_rs, m_re, m_rsv, m_rev;

  task automatic model_reset();
    m_occ = 0; m_hour = 0; m_dd = 0; m_blk = 0; m_rd = 0;
    m_rs = 0; m_re = 0; m_rsv = 0; m_rev = 0;
    for (int i = 0; i < NH; i++) m_log[i] = 0;
  endtask

  task automatic check_all();
    chk("occupancy", 32'(occupancy), m_occ);
    chk("full", 32'(full), (m_occ == CAP) ? 1 : 0);
    chk("empty", 32'(empty), (m_occ == 0) ? 1 : 0);
    chk("blocked", 32'(blocked), m_blk);
    chk("hour", 32'(hour), m_hour);
    chk("day_done", 32'(day_done), m_dd);
`ifdef LOT_HISTORY_EN
    chk("rd_count", 32'(rd_count), m_rd);
    chk("rush_start", 32'(rush_start), m_rs);
    chk("rush_end", 32'(rush_end), m_re);
    chk("rush_start_vld", 32'(rush_start_vld), m_rsv);
    chk("rush_end_vld", 32'(rush_end_vld), m_rev);
`else
    chk("rd_count", 32'(rd_count), 0);
    chk("rush_out", 32'({rush_start, rush_end, rush_start_vld, rush_end_vld}), 0);
`endif
  endtask

  task automatic step(input bit e, input bit x, input bit nh, input int rh);
    int old_occ;
    @(negedge clk);
    enter = e; exit = x; next_hour = nh; rd_hour = 3'(rh);
    @(posedge clk);
    #1;
    enter = 1'b0; exit = 1'b0; next_hour = 1'b0;
    m_rd    = m_log[rh];
    old_occ = m_occ;
    m_blk   = 0;
    if (e && !x) begin
      if (m_occ == CAP) m_blk = 1;
      else begin
        m_occ++;
        if (!m_dd && m_log[m_hour] < (1 << CW) - 1) m_log[m_hour]++;
      end
    end else if (x && !e && m_occ > 0) begin
      m_occ--;
    end
    if (!m_dd) begin
      if (!m_rsv && m_occ == CAP && old_occ != CAP) begin
        m_rs = m_hour; m_rsv = 1;
      end else if (m_rsv && !m_rev && m_occ == 0 && old_occ != 0) begin
        m_re = m_hour; m_rev = 1;
      end
      if (nh) begin
        if (m_hour < NH - 1) m_hour++;
        else m_dd = 1;
      end
    end
    check_all();
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  int exp_fill [4] = '{1, 2, 3, 3};

  initial begin
    reset = 1'b0; enter = 1'b0; exit = 1'b0; next_hour = 1'b0; rd_hour = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // Mid-count reset.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("pre_reset_occ", 32'(occupancy), 2);
    do_reset();

    // Fill past capacity.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      chk("fill_occ", 32'(occupancy), exp_fill[i]);
      chk("fill_blocked", 32'(blocked), (i == 3) ? 1 : 0);
    end
    step(0, 0, 0, 0);
`ifdef LOT_HISTORY_EN
    chk("log0_after_fill", 32'(rd_count), 3);
`endif

    // Exit from empty, then simultaneous enter+exit at occupancy 1.
    do_reset();
    step(0, 1, 0, 0);
    chk("exit_empty", 32'(empty), 1);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("both_hold", 32'(occupancy), 1);
    step(0, 0, 0, 0);

    // Rush window: fill in hour 2, empty in hour 4, refill in hour 5.
    do_reset();
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 2);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 4);
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 5);
`ifdef LOT_HISTORY_EN
    chk("rush_start_dir", 32'(rush_start), 2);
    chk("rush_end_dir", 32'(rush_end), 4);
`endif

    // End of day: hour sticks at the last one; log frozen.
    do_reset();
    for (int i = 0; i < NH; i++) step(0, 0, 1, 7);
    chk("day_end_hour", 32'(hour), NH - 1);
    chk("day_end_done", 32'(day_done), 1);
    step(1, 0, 0, 7);
    step(1, 0, 1, 7);
    step(0, 0, 0, 7);
    chk("late_occ", 32'(occupancy), 2);

    // Randomized rounds, each starting from an asynchronous reset.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
             $urandom_range(0, 19) == 0, int'($urandom_range(0, NH - 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
